// File: rtl/pulse_tx.sv
// Write-domain pulse encoder: turns event pulses into wr_data toggles spaced HOLD_CYCLES apart.
// Optional sticky overflow output ovf is enabled by defining PULSE_TX_OVF_EN.
module pulse_tx #(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 4
) (
   input  logic             wr_clk,
   input  logic             wr_reset,
   input  logic             pulse_in,
   input  logic             flush,
   output logic             wr_data,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
`ifdef PULSE_TX_OVF_EN
   output logic             ovf,
`endif
   output logic             drop
);

   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0]  HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
   localparam logic [HC_W-1:0]  HOLD_ZERO = {HC_W{1'b0}};
   localparam logic [HC_W-1:0]  HOLD_ONE  = HC_W'(1'b1);
   localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t           state_r, state_next_s;
   logic [HC_W-1:0]  hold_cnt_r, hold_next_s;
   logic [CNT_W-1:0] pending_r, pending_next_s;
   logic             wr_data_r;
   logic             drop_r, drop_next_s;
   logic             launch_s;
   logic             want_s;

   // Launch decision and hold counter sequencing
   always_comb begin
      launch_s     = 1'b0;
      state_next_s = state_r;
      hold_next_s  = hold_cnt_r;
      want_s       = (pulse_in || (pending_r != PEND_ZERO)) && !flush;
      case (state_r)
         IDLE: begin
            if (want_s) begin
               launch_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         HOLD: begin
            if (hold_cnt_r != HOLD_ZERO) begin
               hold_next_s = hold_cnt_r - HOLD_ONE;
            end else if (want_s) begin
               launch_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      if (launch_s) begin
         state_next_s = HOLD;
         hold_next_s  = HOLD_LOAD;
      end else begin
         hold_next_s  = hold_next_s;
      end
   end

   // Pending queue accounting; a launch with no backlog consumes the incoming pulse
   always_comb begin
      pending_next_s = pending_r;
      drop_next_s    = 1'b0;
      if (flush) begin
         pending_next_s = PEND_ZERO;
      end else if (pulse_in && !launch_s) begin
         if (pending_r == PEND_MAX) begin
            drop_next_s = 1'b1;
         end else begin
            pending_next_s = pending_r + PEND_ONE;
         end
      end else if (!pulse_in && launch_s) begin
         pending_next_s = pending_r - PEND_ONE;
      end else begin
         pending_next_s = pending_r;
      end
   end

   // State, counters and output registers
   always_ff @(posedge wr_clk or posedge wr_reset) begin
      if (wr_reset) begin
         state_r    <= IDLE;
         hold_cnt_r <= HOLD_ZERO;
         pending_r  <= PEND_ZERO;
         wr_data_r  <= 1'b0;
         drop_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         hold_cnt_r <= hold_next_s;
         pending_r  <= pending_next_s;
         wr_data_r  <= launch_s ? ~wr_data_r : wr_data_r;
         drop_r     <= drop_next_s;
      end
   end

`ifdef PULSE_TX_OVF_EN
   logic ovf_r;

   // Sticky overflow, rises together with drop
   always_ff @(posedge wr_clk or posedge wr_reset) begin
      if (wr_reset) begin
         ovf_r <= 1'b0;
      end else if (flush) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r | drop_next_s;
      end
   end

   assign ovf = ovf_r;
`endif

   assign wr_data = wr_data_r;
   assign pending = pending_r;
   assign drop    = drop_r;
   assign busy    = (state_r == HOLD) | (pending_r != PEND_ZERO);

endmodule

// File: tb/tb_pulse_tx.sv
// Self-checking bench for pulse_tx with HOLD_CYCLES=4, CNT_W=2.
module tb_pulse_tx;

   logic       wr_clk;
   logic       wr_reset;
   logic       pulse_in;
   logic       flush;
   logic       wr_data;
   logic       busy;
   logic [1:0] pending;
   logic       drop;
`ifdef PULSE_TX_OVF_EN
   logic       ovf;
`endif

   pulse_tx #(.HOLD_CYCLES(4), .CNT_W(2)) dut (
      .wr_clk   (wr_clk),
      .wr_reset (wr_reset),
      .pulse_in (pulse_in),
      .flush    (flush),
      .wr_data  (wr_data),
      .busy     (busy),
      .pending  (pending),
`ifdef PULSE_TX_OVF_EN
      .ovf      (ovf),
`endif
      .drop     (drop)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      logic       rst;
      logic       p;
      logic       f;
      logic       wd;
      logic       b;
      logic [1:0] pd;
      logic       dr;
      logic       ov;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic add(input logic rst, input logic p, input logic f, input logic wd,
                      input logic b, input logic [1:0] pd, input logic dr, input logic ov,
                      input int rep);
      vec_t v;
      for (int i = 0; i < rep; i++) begin
         v.rst = (i == 0) ? rst : 1'b0;
         v.p = p; v.f = f; v.wd = wd; v.b = b; v.pd = pd; v.dr = dr; v.ov = ov;
         tbl.push_back(v);
      end
   endtask

   task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge wr_clk);
      wr_reset = 1'b1;
      pulse_in = 1'b1;
      flush    = 1'b0;
      @(posedge wr_clk);
      #1;
      chk("rst_wr_data", -1, {7'd0, wr_data}, 8'd0);
      chk("rst_busy",    -1, {7'd0, busy},    8'd0);
      chk("rst_pending", -1, {6'd0, pending}, 8'd0);
      chk("rst_drop",    -1, {7'd0, drop},    8'd0);
`ifdef PULSE_TX_OVF_EN
      chk("rst_ovf",     -1, {7'd0, ovf},     8'd0);
`endif
      @(negedge wr_clk);
      wr_reset = 1'b0;
      pulse_in = 1'b0;
   endtask

   initial begin
      vec_t e;
      wr_reset = 1'b1;
      pulse_in = 1'b0;
      flush    = 1'b0;

      // single pulse: toggle at edge 1, busy edges 1-4
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2);
      // three back-to-back pulses: toggles at 1, 5, 9
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2);
      // pulse exactly in the hold_cnt==0 cycle
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1);
      // six pulses: saturation, accept-with-launch, then drop
      add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 4);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 4);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1);
      // flush during a burst, no reset so wr_data starts at 1 and ovf is set
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1);
      add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         @(negedge wr_clk);
         pulse_in = tbl[i].p;
         flush    = tbl[i].f;
         exp_q.push_back(tbl[i]);
         @(posedge wr_clk);
         #1;
         e = exp_q.pop_front();
         chk("wr_data", i, {7'd0, wr_data}, {7'd0, e.wd});
         chk("busy",    i, {7'd0, busy},    {7'd0, e.b});
         chk("pending", i, {6'd0, pending}, {6'd0, e.pd});
         chk("drop",    i, {7'd0, drop},    {7'd0, e.dr});
`ifdef PULSE_TX_OVF_EN
         chk("ovf",     i, {7'd0, ovf},     {7'd0, e.ov});
`endif
      end
      @(negedge wr_clk);
      pulse_in = 1'b0;
      flush    = 1'b0;

      // asynchronous reset mid-HOLD clears wr_data before the next edge
      do_reset();
      @(negedge wr_clk);
      pulse_in = 1'b1;
      @(posedge wr_clk);
      #1;
      chk("midrst_pre_wd", -2, {7'd0, wr_data}, 8'd1);
      @(negedge wr_clk);
      pulse_in = 1'b0;
      #2;
      wr_reset = 1'b1;
      #1;
      chk("midrst_wd",   -2, {7'd0, wr_data}, 8'd0);
      chk("midrst_busy", -2, {7'd0, busy},    8'd0);
      #1;
      wr_reset = 1'b0;
      repeat (2) @(posedge wr_clk);
      #1;
      chk("midrst_idle_wd", -2, {7'd0, wr_data}, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
